// File: rtl/bp_pkg.sv
// Shared encodings and helpers for the branch history table predictor.
package bp_pkg;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  // Two-bit saturating counter step toward the resolved outcome.
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken && ctr != CTR_ST)        nxt = ctr + 2'd1;
    else if (!taken && ctr != CTR_SNT) nxt = ctr - 2'd1;
    return nxt;
  endfunction

  // Table index: word-address bits just above the byte offset.
  function automatic logic [63:0] bp_index(input logic [63:0] pc, input int idx_w);
    return (pc >> 2) & ((64'd1 << idx_w) - 64'd1);
  endfunction

  // Tag: the tag_w bits directly above the index.
  function automatic logic [63:0] bp_tag(input logic [63:0] pc, input int idx_w, input int tag_w);
    return (pc >> (idx_w + 2)) & ((64'd1 << tag_w) - 64'd1);
  endfunction

endpackage

// File: rtl/bp_table.sv
// Direct-mapped predictor storage: one combinational lookup port and one
// synchronous update port that applies the hit/allocate rules in place.
module bp_table
  import bp_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16,
  parameter int TAG_W = 8,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [1:0]       rd_ctr,
  output logic [XLEN-1:0]  rd_target,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic             wr_taken,
  input  logic [XLEN-1:0]  wr_target
);

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [1:0]       ctr;
    logic [XLEN-1:0]  target;
  } entry_t;

  entry_t tbl [DEPTH];
  entry_t cur;
  logic   wr_hit;

  // Lookup returns the pre-edge contents, so a same-cycle update shows next cycle.
  assign rd_valid  = tbl[rd_idx].valid;
  assign rd_tag    = tbl[rd_idx].tag;
  assign rd_ctr    = tbl[rd_idx].ctr;
  assign rd_target = tbl[rd_idx].target;

  assign cur    = tbl[wr_idx];
  assign wr_hit = cur.valid && (cur.tag == wr_tag);

  // Hit: train counter (and target on taken); miss+taken: allocate at WT; miss+not-taken: leave alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) tbl[i] <= '0;
    end else if (wr_en) begin
      if (wr_hit) begin
        tbl[wr_idx].ctr <= ctr_next(cur.ctr, wr_taken);
        if (wr_taken) tbl[wr_idx].target <= wr_target;
      end else if (wr_taken) begin
        tbl[wr_idx] <= '{valid: 1'b1, tag: wr_tag, ctr: CTR_WT, target: wr_target};
      end
    end
  end

endmodule

// File: rtl/branch_predictor_bht.sv
// IF-stage branch predictor: same-cycle lookup, ID-stage training,
// mispredict flush/redirect and saturating branch statistics.
module branch_predictor_bht
  import bp_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16,
  parameter int TAG_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [XLEN-1:0]  if_pc_i,
  output logic             pred_taken_o,
  output logic [XLEN-1:0]  pred_target_o,
  input  logic             upd_valid_i,
  input  logic [XLEN-1:0]  upd_pc_i,
  input  logic             upd_taken_i,
  input  logic [XLEN-1:0]  upd_target_i,
  input  logic             upd_pred_taken_i,
  input  logic [XLEN-1:0]  upd_pred_target_i,
  output logic             flush_o,
  output logic [XLEN-1:0]  redirect_pc_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] mispred_cnt_o
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic [TAG_W-1:0] rd_tag_q, if_tag, wr_tag;
  logic             rd_valid;
  logic [1:0]       rd_ctr;
  logic [XLEN-1:0]  rd_target;
  logic             upd_en, mispredict;

  assign rd_idx = IDX_W'(bp_index(64'(if_pc_i), IDX_W));
  assign if_tag = TAG_W'(bp_tag(64'(if_pc_i), IDX_W, TAG_W));
  assign wr_idx = IDX_W'(bp_index(64'(upd_pc_i), IDX_W));
  assign wr_tag = TAG_W'(bp_tag(64'(upd_pc_i), IDX_W, TAG_W));
  assign upd_en = upd_valid_i && start_i;

  bp_table #(.XLEN(XLEN), .DEPTH(DEPTH), .TAG_W(TAG_W), .IDX_W(IDX_W)) u_table (
    .clk       (clk_i),
    .rst       (rst_i),
    .rd_idx    (rd_idx),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag_q),
    .rd_ctr    (rd_ctr),
    .rd_target (rd_target),
    .wr_en     (upd_en),
    .wr_idx    (wr_idx),
    .wr_tag    (wr_tag),
    .wr_taken  (upd_taken_i),
    .wr_target (upd_target_i)
  );

  assign pred_taken_o  = rd_valid && (rd_tag_q == if_tag) && rd_ctr[1];
  assign pred_target_o = pred_taken_o ? rd_target : '0;

  // Wrong direction, or right "taken" direction with the wrong target.
  assign mispredict = upd_valid_i &&
                      ((upd_pred_taken_i != upd_taken_i) ||
                       (upd_pred_taken_i && upd_taken_i && (upd_pred_target_i != upd_target_i)));

  assign flush_o       = mispredict;
  assign redirect_pc_o = !mispredict  ? '0 :
                         upd_taken_i  ? upd_target_i : upd_pc_i + XLEN'(4);

  // Statistics counters, saturating at all-ones.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      branch_cnt_o  <= '0;
      mispred_cnt_o <= '0;
    end else if (upd_en) begin
      if (branch_cnt_o != '1)                 branch_cnt_o  <= branch_cnt_o + CNT_W'(1);
      if (mispredict && mispred_cnt_o != '1)  mispred_cnt_o <= mispred_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Self-checking bench: directed walk through the predictor rules with literal
// expectations, then randomized traffic against a behavioural table model.
module tb_branch_predictor_bht;

  localparam int XLEN = 32, DEPTH = 16, TAG_W = 8, CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst, start, upd_valid, upd_taken, upd_pred_taken;
  logic [XLEN-1:0]  if_pc, upd_pc, upd_target, upd_pred_target;
  logic             pred_taken, flush;
  logic [XLEN-1:0]  pred_target, redirect_pc;
  logic [CNT_W-1:0] branch_cnt, mispred_cnt;

  int n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  branch_predictor_bht #(.XLEN(XLEN), .DEPTH(DEPTH), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .if_pc_i(if_pc),
    .pred_taken_o(pred_taken), .pred_target_o(pred_target),
    .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_taken_i(upd_taken),
    .upd_target_i(upd_target), .upd_pred_taken_i(upd_pred_taken),
    .upd_pred_target_i(upd_pred_target), .flush_o(flush), .redirect_pc_o(redirect_pc),
    .branch_cnt_o(branch_cnt), .mispred_cnt_o(mispred_cnt)
  );

  // ---- behavioural model: per-entry record, counters as plain integers 0..3
  bit      m_valid [DEPTH];
  int      m_tag   [DEPTH];
  int      m_ctr   [DEPTH];
  longint  m_tgt   [DEPTH];
  longint  m_bcnt, m_mcnt;
  bit      m_live = 0;

  function automatic int idx_of(input longint pc); return int'((pc / 4) % DEPTH); endfunction
  function automatic int tag_of(input longint pc); return int'((pc / (4 * DEPTH)) % 256); endfunction
  function automatic bit m_hit(input longint pc);
    return m_valid[idx_of(pc)] && m_tag[idx_of(pc)] == tag_of(pc);
  endfunction
  function automatic bit m_pred(input longint pc); return m_hit(pc) && m_ctr[idx_of(pc)] >= 2; endfunction
  function automatic bit m_misp();
    if (!upd_valid) return 0;
    if (upd_pred_taken != upd_taken) return 1;
    return upd_taken && upd_pred_target != upd_target;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model state advances on each rising edge from the inputs held across it.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin m_valid[i] = 0; m_tag[i] = 0; m_ctr[i] = 0; m_tgt[i] = 0; end
      m_bcnt = 0; m_mcnt = 0; m_live = 1;
    end else if (upd_valid && start) begin
      int i;
      i = idx_of(upd_pc);
      if (m_mcnt < 65535 && m_misp()) m_mcnt++;
      if (m_bcnt < 65535) m_bcnt++;
      if (m_hit(upd_pc)) begin
        if (upd_taken) begin m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3; m_tgt[i] = upd_target; end
        else m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
      end else if (upd_taken) begin
        m_valid[i] = 1; m_tag[i] = tag_of(upd_pc); m_ctr[i] = 2; m_tgt[i] = upd_target;
      end
    end
  end

  // Compare process: every falling edge once the model has seen a reset.
  always @(negedge clk) begin
    if (m_live) begin
      longint exp_redir;
      exp_redir = !m_misp() ? 0 : upd_taken ? upd_target : (longint'(upd_pc) + 4) % (64'd1 << 32);
      check("pred_taken",  pred_taken, m_pred(if_pc));
      check("pred_target", pred_target, m_pred(if_pc) ? m_tgt[idx_of(if_pc)] : 0);
      check("flush",       flush, m_misp());
      check("redirect_pc", redirect_pc, exp_redir);
      check("branch_cnt",  branch_cnt, m_bcnt);
      check("mispred_cnt", mispred_cnt, m_mcnt);
    end
  end

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic upd(input bit v, input logic [31:0] pc, input bit tk, input logic [31:0] tg,
                     input bit ptk, input logic [31:0] ptg);
    upd_valid = v; upd_pc = pc; upd_taken = tk; upd_target = tg;
    upd_pred_taken = ptk; upd_pred_target = ptg;
  endtask
  task automatic idle(); upd(0, 0, 0, 0, 0, 0); endtask
  // Train pc with an outcome, reporting the prediction the table currently makes.
  task automatic train(input logic [31:0] pc, input bit tk, input logic [31:0] tg);
    if_pc = pc; #1;
    upd(1, pc, tk, tg, pred_taken, pred_target);
    tick(); idle(); #1;
  endtask

  initial begin
    logic [CNT_W-1:0] b0, m0;
    logic [31:0] pool [8];
    rst = 1; start = 1; if_pc = 0; idle();
    tick(); rst = 0;

    // Reset state
    if_pc = 32'h40; #1;
    check("rst_pred", pred_taken, 0); check("rst_tgt", pred_target, 0);
    check("rst_bcnt", branch_cnt, 0); check("rst_mcnt", mispred_cnt, 0);

    // First allocation with mispredict
    upd(1, 32'h40, 1, 32'h100, 0, 0); #1;
    check("alloc_flush", flush, 1); check("alloc_redir", redirect_pc, 32'h100);
    tick(); idle(); #1;
    check("alloc_pred", pred_taken, 1); check("alloc_tgt", pred_target, 32'h100);
    check("alloc_mcnt", mispred_cnt, 1); check("alloc_bcnt", branch_cnt, 1);

    // Counter walk: WT -> WNT -> SNT, then up to ST and saturate, then back to WT
    train(32'h40, 0, 0); if_pc = 32'h40; #1; check("walk_wnt", pred_taken, 0);
    train(32'h40, 0, 0); if_pc = 32'h40; #1; check("walk_snt", pred_taken, 0);
    train(32'h40, 1, 32'h100); train(32'h40, 1, 32'h100); train(32'h40, 1, 32'h100);
    train(32'h40, 1, 32'h100);
    train(32'h40, 0, 0); if_pc = 32'h40; #1;
    check("walk_wt_pred", pred_taken, 1); check("walk_wt_tgt", pred_target, 32'h100);

    // Aliasing: 0x440 evicts 0x40 at index 0
    train(32'h440, 1, 32'h300);
    if_pc = 32'h40;  #1; check("alias_old", pred_taken, 0);
    if_pc = 32'h440; #1; check("alias_new", pred_taken, 1); check("alias_tgt", pred_target, 32'h300);

    // Same-cycle lookup/update with target mismatch
    train(32'h40, 1, 32'h100);
    if_pc = 32'h40; upd(1, 32'h40, 1, 32'h200, 1, 32'h100); #1;
    check("same_old_tgt", pred_target, 32'h100);
    check("tgt_flush", flush, 1); check("tgt_redir", redirect_pc, 32'h200);
    tick(); idle(); #1;
    check("same_new_tgt", pred_target, 32'h200);

    // Frozen: update ignored, flush still computed
    b0 = branch_cnt; m0 = mispred_cnt;
    start = 0; upd(1, 32'h40, 0, 0, 1, 32'h200); #1;
    check("frz_flush", flush, 1); check("frz_redir", redirect_pc, 32'h44);
    tick(); idle(); start = 1; #1;
    check("frz_pred", pred_taken, 1); check("frz_tgt", pred_target, 32'h200);
    check("frz_bcnt", branch_cnt, b0); check("frz_mcnt", mispred_cnt, m0);

    // Reset wins over a simultaneous update
    rst = 1; upd(1, 32'h80, 1, 32'h500, 0, 0);
    tick(); rst = 0; idle();
    if_pc = 32'h80; #1; check("rstupd_pred", pred_taken, 0);
    if_pc = 32'h40; #1; check("rstupd_pred40", pred_taken, 0);
    check("rstupd_bcnt", branch_cnt, 0); check("rstupd_mcnt", mispred_cnt, 0);

    // Randomized traffic over a small PC pool so hits, aliases and evictions recur
    for (int i = 0; i < 8; i++) pool[i] = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] p;
      p = pool[$urandom_range(0, 7)];
      if_pc = pool[$urandom_range(0, 7)];
      start = ($urandom_range(0, 9) != 0);
      rst = ($urandom_range(0, 199) == 0);
      upd($urandom_range(0, 3) != 0, p, $urandom_range(0, 1),
          32'($urandom_range(0, 3)) << 8, $urandom_range(0, 1), 32'($urandom_range(0, 3)) << 8);
      tick();
    end
    rst = 0; idle(); tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
